and_operand_collector: RTL
==========================

// Module: and_operand_collector
// PURPOSE
//   Serial-to-parallel operand collector for the 8-input AND stage.
//   Accepts PORT_NUM operand words one per handshake and presents them together on slot_a..slot_h.
//   Unused slots are held at all-ones, the AND identity, so the downstream result depends only on loaded words.
//   Sits directly upstream of the 8-input AND stage; slot_a..slot_h wire straight to its a..h inputs.
// PARAMETERS
//   PORT_NUM  2  number of operands per group, legal 1..8; slots at index >= PORT_NUM stay all-ones
//   WIDTH     8  operand width in bits, legal >= 1
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   flush      in   1      discard partial or presented group; return to LOAD
//   in_valid   in   1      in_data holds a valid operand
//   in_ready   out  1      collector can accept an operand this cycle
//   in_data    in   WIDTH  operand word
//   out_valid  out  1      slot_a..slot_h hold a complete group
//   out_ready  in   1      consumer takes the group this cycle
//   fill_cnt   out  4      operands accepted into the current group, 0..PORT_NUM
//   slot_a..slot_h  out  WIDTH each  operand slots 0..7 to the AND stage
// BEHAVIOUR
//   Clock, reset and slot state
//   - One clock (clk). Reset is synchronous, active-high (rst).
//   - State on reset: state=LOAD, fill_cnt=0, out_valid=0, all slots={WIDTH{1'b1}}.
//   - in_ready is combinational: (state==LOAD) && !rst, so it is 0 while rst is high.
//   - Slots are registered. Slot i changes only on a load into slot i, on reset, or on group clear.
//   - Group clear: all slots go to all-ones and fill_cnt goes to 0.
//   FSM, two states
//   - LOAD:
//     - On accept (in_valid && in_ready), in_data is written to slot[fill_cnt] and fill_cnt increments.
//     - If that accept makes fill_cnt reach PORT_NUM, next state is PRESENT.
//     - No accept: hold all state.
//   - PRESENT:
//     - out_valid=1 and in_ready=0; slots and fill_cnt (=PORT_NUM) are held stable.
//     - On out_ready=1: group clear and next state LOAD.
//     - out_valid and out_ready may both be high; no dependency on out_ready before out_valid.
//   Timing
//   - Latency: the last operand is accepted at edge N; out_valid=1 in the cycle after edge N.
//   - No bypass from input to output; the earliest next accept is the cycle after the consume edge.
//   - Peak throughput is one group per PORT_NUM+1 cycles.
//   Boundary cases
//   - flush=1 in any state: group clear, state=LOAD, out_valid=0 next cycle.
//     flush has priority over a same-cycle accept (word dropped) and over out_ready.
//   - rst has priority over flush, accept and out_ready.
//   - rst mid-group: partial operands are lost; no output pulse.
//   - PORT_NUM=1: every accept goes to PRESENT; only slot_a ever loads.
//   - PORT_NUM=8: fill_cnt reaches 8 with no wrap; the increment saturates at PORT_NUM.
//   - in_valid while in PRESENT: ignored; the producer must hold its word until in_ready.
//   - X on in_data with in_valid=0 must not propagate into any slot.
// TESTING (WIDTH=8 unless stated)
//   - Reset: rst high 2 cycles -> out_valid=0, fill_cnt=0, all slots=8'hFF; in_ready=0 during rst, 1 after.
//   - Basic, PORT_NUM=2: load 8'hF0 then 8'h3C.
//     -> out_valid=1 one cycle after the 2nd accept; slot_a=F0, slot_b=3C, slot_c..h=FF; AND output=8'h30.
//   - Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new data.
//     -> slots stable, in_ready=0, no accept; out_ready=1 -> next cycle out_valid=0, slots=FF, fill_cnt=0.
//   - Flush, PORT_NUM=4: load 2 words, then flush with in_valid=1 in the same cycle.
//     -> fill_cnt=0, slots all FF, flushed word absent; the next 4 words form a clean group.
//   - PORT_NUM=8: load 8'h01..8'h08 back-to-back -> fill_cnt=8, slot_a=01 ... slot_h=08, out_valid=1.
//   - PORT_NUM=1: stream AA, 55 with out_ready=1 -> 2 groups each 2 cycles apart; slot_a=AA then 55.

Source files
------------

// File: rtl/and_operand_collector_if.sv
// rtl/and_operand_collector_if.sv - producer/consumer bundle for the AND operand collector
interface and_operand_collector_if #(
  parameter int WIDTH = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       fill_cnt;
  logic [WIDTH-1:0] slot_a;
  logic [WIDTH-1:0] slot_b;
  logic [WIDTH-1:0] slot_c;
  logic [WIDTH-1:0] slot_d;
  logic [WIDTH-1:0] slot_e;
  logic [WIDTH-1:0] slot_f;
  logic [WIDTH-1:0] slot_g;
  logic [WIDTH-1:0] slot_h;

  // Producer and consumer side: feeds operands, takes groups.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, fill_cnt,
    input  slot_a, slot_b, slot_c, slot_d, slot_e, slot_f, slot_g, slot_h
  );

  // Collector side.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, fill_cnt,
    output slot_a, slot_b, slot_c, slot_d, slot_e, slot_f, slot_g, slot_h
  );
endinterface

// File: rtl/and_operand_collector.sv
// rtl/and_operand_collector.sv - serial-to-parallel operand collector for the 8-input AND stage
module and_operand_collector #(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 8
) (
  input logic                 clk,
  input logic                 rst,
  and_operand_collector_if.slave bus
);

  typedef enum logic {
    LOAD    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [3:0]       PORT_CNT = 4'(PORT_NUM);
  // All-ones is the AND identity, so empty slots never mask loaded bits.
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  state_t           state;
  logic [3:0]       fill_cnt;
  logic             out_valid;
  logic [WIDTH-1:0] slots [8];

  // Accept only while collecting; forced low during reset.
  assign bus.in_ready  = (state == LOAD) && !rst;
  assign bus.out_valid = out_valid;
  assign bus.fill_cnt  = fill_cnt;
  assign bus.slot_a    = slots[0];
  assign bus.slot_b    = slots[1];
  assign bus.slot_c    = slots[2];
  assign bus.slot_d    = slots[3];
  assign bus.slot_e    = slots[4];
  assign bus.slot_f    = slots[5];
  assign bus.slot_g    = slots[6];
  assign bus.slot_h    = slots[7];

  // Collect/present FSM; reset beats flush, flush beats accept and consume.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state     <= LOAD;
      fill_cnt  <= 4'd0;
      out_valid <= 1'b0;
      for (int i = 0; i < 8; i++) slots[i] <= ONES;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            // Slots at or beyond PORT_NUM are never addressed and stay all-ones.
            for (int i = 0; i < 8; i++) begin
              if ((i < PORT_NUM) && (fill_cnt == 4'(i))) slots[i] <= bus.in_data;
            end
            if (fill_cnt != PORT_CNT) fill_cnt <= fill_cnt + 4'd1;
            if ((fill_cnt + 4'd1) >= PORT_CNT) begin
              state     <= PRESENT;
              out_valid <= 1'b1;
            end
          end
        end
        PRESENT: begin
          // Group stays frozen until the consumer takes it.
          if (bus.out_ready) begin
            state     <= LOAD;
            fill_cnt  <= 4'd0;
            out_valid <= 1'b0;
            for (int i = 0; i < 8; i++) slots[i] <= ONES;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
